// File: rtl/vga_mode_sequencer.sv
// rtl/vga_mode_sequencer.sv - shadow/active video timing registers with validated, blanked mode switch
module vga_mode_sequencer #(
  parameter int C_bits_x       = 11,
  parameter int C_bits_y       = 11,
  parameter int C_blank_frames = 2,
  parameter int C_rst_x        = 1280,
  parameter int C_rst_hfp      = 82,
  parameter int C_rst_hpulse   = 80,
  parameter int C_rst_hbp      = 216,
  parameter int C_rst_y        = 720,
  parameter int C_rst_vfp      = 3,
  parameter int C_rst_vpulse   = 5,
  parameter int C_rst_vbp      = 22
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [15:0]         cfg_data,
  input  logic                commit,
  output logic                busy,
  output logic                done,
  output logic                error,
  input  logic                in_vsync,
  output logic [C_bits_x-1:0] resolution_x,
  output logic [C_bits_x-1:0] hsync_front_porch,
  output logic [C_bits_x-1:0] hsync_pulse,
  output logic [C_bits_x-1:0] hsync_back_porch,
  output logic [C_bits_y-1:0] resolution_y,
  output logic [C_bits_y-1:0] vsync_front_porch,
  output logic [C_bits_y-1:0] vsync_pulse,
  output logic [C_bits_y-1:0] vsync_back_porch,
  output logic                timing_reload,
  output logic                force_blank
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WAIT_EDGE, S_BLANK, S_LOAD, S_SETTLE
  } state_t;

  localparam int CW = (C_blank_frames > 1) ? $clog2(C_blank_frames) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((C_blank_frames > 0) ? C_blank_frames - 1 : 0);
  localparam bit NO_BLANK = (C_blank_frames == 0);

  localparam logic [C_bits_x+1:0] HLIM = {2'b01, {C_bits_x{1'b0}}};
  localparam logic [C_bits_y+1:0] VLIM = {2'b01, {C_bits_y{1'b0}}};

  localparam logic [C_bits_x-1:0] RST_X [4] = '{C_bits_x'(C_rst_x), C_bits_x'(C_rst_hfp),
                                               C_bits_x'(C_rst_hpulse), C_bits_x'(C_rst_hbp)};
  localparam logic [C_bits_y-1:0] RST_Y [4] = '{C_bits_y'(C_rst_y), C_bits_y'(C_rst_vfp),
                                               C_bits_y'(C_rst_vpulse), C_bits_y'(C_rst_vbp)};

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              vsync_q, vsync_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              rst_dly_q, rst_dly_d;
  logic              reload_pend_q, reload_pend_d;
  logic [C_bits_x-1:0] shx_q [4];
  logic [C_bits_x-1:0] shx_d [4];
  logic [C_bits_x-1:0] acx_q [4];
  logic [C_bits_x-1:0] acx_d [4];
  logic [C_bits_y-1:0] shy_q [4];
  logic [C_bits_y-1:0] shy_d [4];
  logic [C_bits_y-1:0] acy_q [4];
  logic [C_bits_y-1:0] acy_d [4];

  logic                vs_edge;
  logic                cfg_ok;
  logic [C_bits_x+1:0] hsum;
  logic [C_bits_y+1:0] vsum;
  logic                unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_data;
  assign vs_edge = in_vsync & ~vsync_q;

  // Sums are two bits wider than a field so four full-scale fields cannot wrap.
  assign hsum = {2'b00, shx_q[0]} + {2'b00, shx_q[1]} + {2'b00, shx_q[2]} + {2'b00, shx_q[3]};
  assign vsum = {2'b00, shy_q[0]} + {2'b00, shy_q[1]} + {2'b00, shy_q[2]} + {2'b00, shy_q[3]};
  assign cfg_ok = (shx_q[0] != '0) && (shx_q[2] != '0) &&
                  (shy_q[0] != '0) && (shy_q[2] != '0) &&
                  (hsum <= HLIM) && (vsum <= VLIM);

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      vsync_q       <= 1'b1;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      rst_dly_q     <= 1'b1;
      reload_pend_q <= 1'b0;
      shx_q         <= RST_X;
      acx_q         <= RST_X;
      shy_q         <= RST_Y;
      acy_q         <= RST_Y;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      vsync_q       <= vsync_d;
      done_q        <= done_d;
      error_q       <= error_d;
      rst_dly_q     <= rst_dly_d;
      reload_pend_q <= reload_pend_d;
      shx_q         <= shx_d;
      acx_q         <= acx_d;
      shy_q         <= shy_d;
      acy_q         <= acy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    vsync_d       = in_vsync;
    done_d        = 1'b0;
    error_d       = error_q;
    rst_dly_d     = 1'b0;
    reload_pend_d = rst_dly_q;
    shx_d         = shx_q;
    shy_d         = shy_q;
    acx_d         = acx_q;
    acy_d         = acy_q;

    // Host writes land only while idle, so a commit in the same cycle checks the new value.
    if (state_q == S_IDLE && cfg_we) begin
      if (!cfg_addr[2]) shx_d[cfg_addr[1:0]] = cfg_data[C_bits_x-1:0];
      else              shy_d[cfg_addr[1:0]] = cfg_data[C_bits_y-1:0];
    end

    case (state_q)
      S_IDLE:      if (commit) state_d = S_CHECK;
      S_CHECK: begin
        if (cfg_ok) begin
          error_d = 1'b0;
          state_d = S_WAIT_EDGE;
        end else begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_EDGE: begin
        if (vs_edge) begin
          cnt_d = '0;
          if (NO_BLANK) state_d = S_LOAD;
          else          state_d = S_BLANK;
        end
      end
      S_BLANK: begin
        if (vs_edge) begin
          if (cnt_q == CNT_LAST) state_d = S_LOAD;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      S_LOAD:      state_d = S_SETTLE;
      S_SETTLE: begin
        if (vs_edge) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default:     state_d = S_IDLE;
    endcase

    if (state_d == S_LOAD && state_q != S_LOAD) begin
      acx_d = shx_q;
      acy_d = shy_q;
    end
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = done_q;
    error         = error_q;
    timing_reload = (state_q == S_LOAD) | reload_pend_q;
    force_blank   = (state_q == S_BLANK) || (state_q == S_LOAD) || (state_q == S_SETTLE) ||
                    ((state_q == S_WAIT_EDGE) && NO_BLANK);
    resolution_x      = acx_q[0];
    hsync_front_porch = acx_q[1];
    hsync_pulse       = acx_q[2];
    hsync_back_porch  = acx_q[3];
    resolution_y      = acy_q[0];
    vsync_front_porch = acy_q[1];
    vsync_pulse       = acy_q[2];
    vsync_back_porch  = acy_q[3];
  end

endmodule
